axis_eth_hdr_extract: RTL

- Sits directly downstream of the pcap replay AXI-Stream source and upstream of the pcap writer sink.
- Passes the packet stream through unchanged with one register stage.
- Extracts Ethernet and IPv4 header fields from each packet's first flit and emits one metadata record per packet on a separate valid/ready channel, after tlast.
- Keeps packet and runt statistics counters.

---
 rtl/axis_pkg.sv | 32 +++
 rtl/axis_reg_slice.sv | 59 +++++
 rtl/axis_eth_hdr_extract.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream/header types, constants and popcount helper
package axis_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int ETH_HDR_BYTES  = 14;
  localparam int IPV4_MIN_BYTES = 34;
  // Widest tkeep the popcount helper handles (TDATA_WIDTH up to 2048).
  localparam int KEEP_MAX       = 256;

  // pkt_len is carried at 32 bits; users truncate to their own LEN_WIDTH.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        is_ipv4;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [31:0] pkt_len;
    logic        runt;
  } eth_hdr_t;

  function automatic logic [15:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - full-throughput register slice with skid buffer
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] m_data_q, m_data_d, sk_data_q, sk_data_d;
  logic             m_valid_q, m_valid_d, sk_valid_q, sk_valid_d;

  // Ready is registered: only a full skid entry blocks the upstream side.
  assign s_ready_o = !sk_valid_q;
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;

  // Next state: refill the output stage (skid first), else park input in skid.
  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    sk_data_d  = sk_data_q;
    sk_valid_d = sk_valid_q;
    if (!m_valid_q || m_ready_i) begin
      if (sk_valid_q) begin
        m_data_d   = sk_data_q;
        m_valid_d  = 1'b1;
        sk_valid_d = 1'b0;
      end else begin
        m_valid_d = s_valid_i;
        if (s_valid_i) m_data_d = s_data_i;
      end
    end else if (s_valid_i && !sk_valid_q) begin
      sk_data_d  = s_data_i;
      sk_valid_d = 1'b1;
    end
  end

  // Slice registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_valid_q <= 1'b0;
    end else begin
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      sk_data_q  <= sk_data_d;
      sk_valid_q <= sk_valid_d;
    end
  end

endmodule

// File: rtl/axis_eth_hdr_extract.sv
// rtl/axis_eth_hdr_extract.sv - stream pass-through with Ethernet/IPv4 header record per packet
module axis_eth_hdr_extract
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_hdr_valid,
  input  logic                     m_hdr_ready,
  output logic [47:0]              m_hdr_dst_mac,
  output logic [47:0]              m_hdr_src_mac,
  output logic [15:0]              m_hdr_ethertype,
  output logic                     m_hdr_is_ipv4,
  output logic [7:0]               m_hdr_ip_proto,
  output logic [31:0]              m_hdr_ip_src,
  output logic [31:0]              m_hdr_ip_dst,
  output logic [LEN_WIDTH-1:0]     m_hdr_pkt_len,
  output logic                     m_hdr_runt,
  output logic [31:0]              stat_pkt_cnt,
  output logic [31:0]              stat_runt_cnt
);

  localparam int KEEP_W   = TDATA_WIDTH / 8;
  localparam int SLICE_W  = TDATA_WIDTH + KEEP_W + 1;
  localparam int HDR_BITS = IPV4_MIN_BYTES * 8;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic {ST_FIRST, ST_BODY} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, len_fin;
  logic [HDR_BITS-1:0]   stg_q, stg_d, hdr_src;
  eth_hdr_t              hdr_q, hdr_d, rec;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d, runt_cnt_q, runt_cnt_d;
  logic [15:0]           flit_len;
  logic [32:0]           len_acc;
  logic [7:0]            mb [IPV4_MIN_BYTES];
  logic                  slice_ready, stall, s_hs;

  // A new packet may not start while the previous record is still unconsumed.
  assign stall         = (state_q == ST_FIRST) && hdr_valid_q && !m_hdr_ready;
  assign s_axis_tready = slice_ready && !stall;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  axis_reg_slice #(.WIDTH(SLICE_W)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .s_valid_i (s_axis_tvalid && !stall),
    .s_ready_o (slice_ready),
    .m_data_o  ({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  // Length including this flit (saturating) and the record built from it.
  always_comb begin
    flit_len = popcount(KEEP_MAX'(s_axis_tkeep));
    len_acc  = (state_q == ST_FIRST) ? 33'(flit_len) : 33'(len_q) + 33'(flit_len);
    len_fin  = (len_acc > 33'(LEN_MAX)) ? LEN_MAX : len_acc[LEN_WIDTH-1:0];
    hdr_src  = (state_q == ST_FIRST) ? s_axis_tdata[HDR_BITS-1:0] : stg_q;
    for (int i = 0; i < IPV4_MIN_BYTES; i++) begin
      mb[i] = (33'(len_fin) > 33'(i)) ? hdr_src[8*i +: 8] : 8'h00;
    end
    rec           = '0;
    rec.dst_mac   = {mb[0], mb[1], mb[2], mb[3], mb[4], mb[5]};
    rec.src_mac   = {mb[6], mb[7], mb[8], mb[9], mb[10], mb[11]};
    rec.ethertype = {mb[12], mb[13]};
    rec.is_ipv4   = ({mb[12], mb[13]} == ETHERTYPE_IPV4) && (mb[14][7:4] == 4'd4) &&
                    (33'(len_fin) >= 33'(IPV4_MIN_BYTES));
    if (rec.is_ipv4) begin
      rec.ip_proto = mb[23];
      rec.ip_src   = {mb[26], mb[27], mb[28], mb[29]};
      rec.ip_dst   = {mb[30], mb[31], mb[32], mb[33]};
    end
    rec.pkt_len = 32'(len_fin);
    rec.runt    = 33'(len_fin) < 33'(ETH_HDR_BYTES);
  end

  // FSM next state: capture on first flit, accumulate in body, publish on tlast.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    stg_d       = stg_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q;
    pkt_cnt_d   = pkt_cnt_q;
    runt_cnt_d  = runt_cnt_q;
    if (hdr_valid_q && m_hdr_ready) hdr_valid_d = 1'b0;
    if (s_hs) begin
      len_d = len_fin;
      if (state_q == ST_FIRST) stg_d = s_axis_tdata[HDR_BITS-1:0];
      if (s_axis_tlast) begin
        state_d     = ST_FIRST;
        hdr_d       = rec;
        hdr_valid_d = 1'b1;
        pkt_cnt_d   = pkt_cnt_q + 32'd1;
        if (rec.runt) runt_cnt_d = runt_cnt_q + 32'd1;
      end else begin
        state_d = ST_BODY;
      end
    end
  end

  // FSM, accumulator, staging, record and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      len_q       <= '0;
      stg_q       <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      runt_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      stg_q       <= stg_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      runt_cnt_q  <= runt_cnt_d;
    end
  end

  assign m_hdr_valid     = hdr_valid_q;
  assign m_hdr_dst_mac   = hdr_q.dst_mac;
  assign m_hdr_src_mac   = hdr_q.src_mac;
  assign m_hdr_ethertype = hdr_q.ethertype;
  assign m_hdr_is_ipv4   = hdr_q.is_ipv4;
  assign m_hdr_ip_proto  = hdr_q.ip_proto;
  assign m_hdr_ip_src    = hdr_q.ip_src;
  assign m_hdr_ip_dst    = hdr_q.ip_dst;
  assign m_hdr_pkt_len   = LEN_WIDTH'(hdr_q.pkt_len);
  assign m_hdr_runt      = hdr_q.runt;
  assign stat_pkt_cnt    = pkt_cnt_q;
  assign stat_runt_cnt   = runt_cnt_q;

endmodule
